// File: rtl/bubble_pkg.sv
// Shared definitions for the bubble-sort sequencer: state encoding, ALU opcode, default widths.
package bubble_pkg;

  localparam int unsigned W_DEF     = 16;
  localparam int unsigned DEPTH_DEF = 8;

  localparam logic OP_CMP = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    RD_B,
    LATCH_B,
    CMP,
    WR_A,
    WR_B,
    NEXT,
    DONE
  } state_t;

endpackage

// File: rtl/bubble_sort_ctrl.sv
// Bubble-sorts len words of an external synchronous RAM in place, ascending,
// using the shared ALU compare; a pass with no swaps ends the sort early.
module bubble_sort_ctrl
  import bubble_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [W-1:0]  mem_rd_data,
  output logic          mem_wr_en,
  output logic [W-1:0]  mem_wr_data,
  output logic [W-1:0]  alu_op1,
  output logic [W-1:0]  alu_op2,
  output logic          alu_operation,
  input  logic          alu_lt
);

  localparam int unsigned LW = AW + 1;

  state_t        state, state_next;
  logic [AW-1:0] i, i_next;
  logic [AW-1:0] last, last_next;
  logic          swapped, swapped_next;
  logic [W-1:0]  reg_a, reg_b;
  logic [AW:0]   len_eff;

  assign alu_op1 = reg_b;
  assign alu_op2 = reg_a;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and loop-index decisions
  always_comb begin
    state_next   = state;
    i_next       = i;
    last_next    = last;
    swapped_next = swapped;
    len_eff      = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_eff >= LW'(2)) begin
            i_next       = '0;
            last_next    = AW'(len_eff - LW'(1));
            swapped_next = 1'b0;
            state_next   = RD_A;
          end else begin
            state_next = DONE;
          end
        end
      end
      RD_A:    state_next = RD_B;
      RD_B:    state_next = LATCH_B;
      LATCH_B: state_next = CMP;
      // Strict less-than keeps equal neighbours in place
      CMP:     state_next = alu_lt ? WR_A : NEXT;
      WR_A:    state_next = WR_B;
      WR_B: begin
        swapped_next = 1'b1;
        state_next   = NEXT;
      end
      NEXT: begin
        if ((i + AW'(1)) < last) begin
          i_next     = i + AW'(1);
          state_next = RD_A;
        end else if (!swapped || (last == AW'(1))) begin
          state_next = DONE;
        end else begin
          last_next    = last - AW'(1);
          i_next       = '0;
          swapped_next = 1'b0;
          state_next   = RD_A;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      i             <= '0;
      last          <= '0;
      swapped       <= 1'b0;
      reg_a         <= '0;
      reg_b         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_addr      <= '0;
      mem_wr_en     <= 1'b0;
      mem_wr_data   <= '0;
      alu_operation <= 1'b0;
    end else begin
      i       <= i_next;
      last    <= last_next;
      swapped <= swapped_next;
      if (state == RD_B)    reg_a <= mem_rd_data;
      if (state == LATCH_B) reg_b <= mem_rd_data;

      busy          <= (state_next != IDLE) && (state_next != DONE);
      done          <= (state_next == DONE);
      mem_wr_en     <= (state_next == WR_A) || (state_next == WR_B);
      alu_operation <= (state_next == CMP) ? OP_CMP : ~OP_CMP;

      case (state_next)
        RD_A:    mem_addr <= i_next;
        RD_B:    mem_addr <= i_next + AW'(1);
        WR_A: begin
          mem_addr    <= i_next;
          mem_wr_data <= reg_b;
        end
        WR_B: begin
          mem_addr    <= i_next + AW'(1);
          mem_wr_data <= reg_a;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Bench for bubble_sort_ctrl: sync RAM + compare ALU, array-level bubble-sort reference model.
module tb_bubble_sort_ctrl;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic        busy, done;
  logic [2:0]  mem_addr;
  logic [15:0] mem_rd_data;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] alu_op1, alu_op2;
  logic        alu_operation;
  logic        alu_lt;

  logic [15:0] ram [8];
  logic [15:0] load_v [8];
  logic        load;

  int          init_v [8];
  int          exp_final [8];
  wr_t         exp_q [$];
  int          exp_cmp, exp_swp, exp_lat;
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cnt, wr_seen, lat;

  always #5 clk = ~clk;

  bubble_sort_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_operation(alu_operation), .alu_lt(alu_lt)
  );

  assign alu_lt = (alu_operation == 1'b1) && (alu_op1 < alu_op2);

  // Synchronous RAM with a bench-side bulk load port
  always @(posedge clk) begin
    if (load) begin
      for (int k = 0; k < 8; k++) ram[k] <= load_v[k];
    end else if (mem_wr_en) begin
      ram[mem_addr] <= mem_wr_data;
    end
    mem_rd_data <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Reference: plain bubble sort with early exit, recording each swap's two writes
  task automatic model_run(input int n);
    int  ne;
    int  a [8];
    int  t;
    wr_t e;
    ne = (n > 8) ? 8 : n;
    for (int k = 0; k < 8; k++) a[k] = init_v[k];
    exp_q.delete();
    exp_cmp = 0;
    exp_swp = 0;
    if (ne >= 2) begin
      for (int lst = ne - 1; lst >= 1; lst--) begin
        bit sw;
        sw = 1'b0;
        for (int p = 0; p < lst; p++) begin
          exp_cmp++;
          if (a[p+1] < a[p]) begin
            e.addr = 3'(p);     e.data = 16'(a[p+1]); exp_q.push_back(e);
            e.addr = 3'(p + 1); e.data = 16'(a[p]);   exp_q.push_back(e);
            t = a[p]; a[p] = a[p+1]; a[p+1] = t;
            sw = 1'b1;
            exp_swp++;
          end
        end
        if (!sw) break;
      end
    end
    for (int k = 0; k < 8; k++) exp_final[k] = a[k];
    exp_lat = (ne >= 2) ? 1 + 5 * exp_cmp + 2 * exp_swp : 1;
  endtask

  // Per-cycle compare against the expected write stream and handshake rules
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) chk("done_while_busy", 64'(busy), 64'd0);
      if (mem_wr_en) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(e.addr));
          chk("wr_data", 64'(mem_wr_data), 64'(e.data));
        end
      end
    end
  end

  task automatic load_ram();
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) load_v[k] = 16'(init_v[k]);
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic do_sort(input int n, input bit poke);
    load_ram();
    model_run(n);
    busy_cnt = 0;
    wr_seen  = 0;
    lat      = 0;
    start = 1'b1;
    len   = 4'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (poke && c == 3) begin start = 1'b1; len = 4'd8; end
      if (poke && c == 4) start = 1'b0;
      if (done) begin lat = c; break; end
    end
    chk("done_seen", 64'(lat != 0), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    @(negedge clk);
    chk("done_one_pulse", {62'd0, done, busy}, 64'd0);
    for (int k = 0; k < 8; k++) chk("final_ram", 64'(ram[k]), 64'(exp_final[k]));
    chk("writes_left", 64'(exp_q.size()), 64'd0);
    chk("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
  endtask

  task automatic set4(input int a0, input int a1, input int a2, input int a3);
    init_v[0] = a0; init_v[1] = a1; init_v[2] = a2; init_v[3] = a3;
    for (int k = 4; k < 8; k++) init_v[k] = 100 + k;
  endtask

  function automatic logic [63:0] outs();
    return {9'd0, busy, done, mem_wr_en, alu_operation, mem_addr, mem_wr_data, alu_op1, alu_op2};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; load = 1'b0;
    busy_cnt = 0; wr_seen = 0;
    for (int k = 0; k < 8; k++) load_v[k] = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'd0);
    rst = 1'b0;

    set4(5, 9, 0, 0);
    do_sort(2, 1'b0);
    chk("sorted_pair_latency", 64'(lat), 64'd6);
    chk("sorted_pair_writes", 64'(wr_seen), 64'd0);
    chk("sorted_pair_ram", {32'd0, ram[0], ram[1]}, {32'd0, 16'd5, 16'd9});

    set4(9, 5, 0, 0);
    do_sort(2, 1'b0);
    chk("swap_pair_latency", 64'(lat), 64'd8);
    chk("swap_pair_ram", {32'd0, ram[0], ram[1]}, {32'd0, 16'd5, 16'd9});

    set4(4, 3, 2, 1);
    do_sort(4, 1'b1);
    chk("rev4_writes", 64'(wr_seen), 64'd12);
    chk("rev4_ram", {ram[0], ram[1], ram[2], ram[3]}, {16'd1, 16'd2, 16'd3, 16'd4});

    set4(7, 7, 1, 7);
    do_sort(4, 1'b0);
    chk("equal_writes", 64'(wr_seen), 64'd4);
    chk("equal_ram", {ram[0], ram[1], ram[2], ram[3]}, {16'd1, 16'd7, 16'd7, 16'd7});

    for (int n = 0; n < 2; n++) begin
      set4(8, 2, 6, 4);
      do_sort(n, 1'b0);
      chk("short_len_latency", 64'(lat), 64'd1);
      chk("short_len_writes", 64'(wr_seen), 64'd0);
    end

    // Reset during WR_B of the first swap
    set4(4, 3, 2, 1);
    load_ram();
    model_run(4);
    wr_seen = 0;
    start = 1'b1; len = 4'd4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (wr_seen == 2) break;
    end
    chk("rst_reached_wr_b", 64'(wr_seen), 64'd2);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_outputs", outs(), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_writes", 64'(wr_seen), 64'd2);
    chk("rst_mid_ram", {ram[0], ram[1], ram[2], ram[3]}, {16'd3, 16'd4, 16'd2, 16'd1});
    for (int k = 0; k < 8; k++) init_v[k] = int'(ram[k]);
    do_sort(4, 1'b0);
    chk("restart_ram", {ram[0], ram[1], ram[2], ram[3]}, {16'd1, 16'd2, 16'd3, 16'd4});

    // Randomized lengths (including clamped ones) and contents
    for (int it = 0; it < 30; it++) begin
      for (int k = 0; k < 8; k++)
        init_v[k] = (it % 2 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 65535));
      do_sort(int'($urandom_range(0, 10)), (it % 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
